// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit 0 of the opcode selects the shifter; bit 1 then selects left.
  function automatic logic is_shift(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the controller (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int unsigned N = 16
);
  logic         i_valid;
  logic         ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic [1:0]   i_control;
  logic [N-1:0] q;
  logic         mayor;
  logic         paridad;
  logic         cero;
  logic         valid;

  modport master (
    output i_valid, i_a, i_b, i_control,
    input  ready, q, mayor, paridad, cero, valid
  );

  modport slave (
    input  i_valid, i_a, i_b, i_control,
    output ready, q, mayor, paridad, cero, valid
  );
endinterface

// File: rtl/alu_shift_step.sv
// Single-bit zero-filling logical shift; reports the bit that falls off.
module alu_shift_step #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] d,
  input  logic         left,
  output logic [N-1:0] y,
  output logic         out_bit
);

  always_comb begin
    y       = '0;
    out_bit = 1'b0;
    if (left) begin
      y       = {d[N-2:0], 1'b0};
      out_bit = d[N-1];
    end else begin
      y       = {1'b0, d[N-1:1]};
      out_bit = d[0];
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub, iterative 1-bit-per-cycle logical shifts.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input logic      i_clk,
  input logic      i_rst,
  alu_seq_if.slave bus
);

  localparam int unsigned SHW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   work_q, work_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           mayor_q, mayor_d;
  logic           valid_q, valid_d;
  logic           ready_q, ready_d;

  logic [N:0]     sum;
  logic [N:0]     diff;
  logic [SHW-1:0] k;
  logic [N-1:0]   step_in;
  logic           step_left;
  logic [N-1:0]   step_y;
  logic           step_out;

  assign sum  = {1'b0, bus.i_a} + {1'b0, bus.i_b};
  assign diff = {1'b0, bus.i_a} - {1'b0, bus.i_b};
  assign k    = bus.i_b[SHW-1:0];

  // The accept edge already performs the first shift, so the shifter sees the
  // live operand in IDLE and the working register afterwards.
  assign step_in   = (state_q == ST_SHIFT) ? work_q : bus.i_a;
  assign step_left = (state_q == ST_SHIFT) ? dir_q  : bus.i_control[1];

  alu_shift_step #(.N(N)) u_step (
    .d       (step_in),
    .left    (step_left),
    .y       (step_y),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mayor_d = mayor_q;
    valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          if (!is_shift(bus.i_control)) begin
            if (bus.i_control == OP_SUB) begin
              q_d     = diff[N-1:0];
              mayor_d = diff[N];
            end else begin
              q_d     = sum[N-1:0];
              mayor_d = sum[N];
            end
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else if (k == '0) begin
            q_d     = bus.i_a;
            mayor_d = 1'b0;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else if (k == SHW'(1)) begin
            q_d     = step_y;
            mayor_d = step_out;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            // cnt holds the shifts still to do after this edge
            work_d  = step_y;
            cnt_d   = k - SHW'(1);
            dir_d   = bus.i_control[1];
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        work_d = step_y;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          q_d     = step_y;
          mayor_d = step_out;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mayor_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mayor_q <= mayor_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.mayor   = mayor_q;
  assign bus.valid   = valid_q;
  assign bus.ready   = ready_q;
  assign bus.paridad = q_q[0];
  assign bus.cero    = (q_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (N = 16).
module tb_alu_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_seq_if #(.N(16)) bus ();

  alu_seq #(.N(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request, scramble the inputs after accept, then wait for valid.
  task automatic do_op(input logic [1:0] ctl, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int rdy_low);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_control = ctl;
    bus.i_a = a;
    bus.i_b = b;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_a = 16'hDEAD;
    bus.i_b = 16'hBEEF;
    bus.i_control = ~ctl;
    lat = -1;
    rdy_low = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!bus.ready) rdy_low++;
      if (bus.valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat, rl;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready !== 1'b1 || bus.cero !== 1'b1 || bus.q !== 16'h0) begin
      errors++; $display("FAIL init_reset: ready=%b cero=%b q=%h expected 1 1 0000", bus.ready, bus.cero, bus.q);
    end
    rst = 1'b0;
    do_op(2'b00, 16'hFFFF, 16'h0003, lat, rl);
    checks++; if (bus.q !== 16'h0002 || bus.mayor !== 1'b1) begin
      errors++; $display("FAIL pre_reset_op: q=%h mayor=%b expected 0002 1", bus.q, bus.mayor);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.q !== 16'h0) begin errors++; $display("FAIL reset_q: got %h expected 0000", bus.q); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.cero !== 1'b1) begin errors++; $display("FAIL reset_cero: got %b expected 1", bus.cero); end
    checks++; if (bus.mayor !== 1'b0 || bus.paridad !== 1'b0) begin
      errors++; $display("FAIL reset_flags: mayor=%b paridad=%b expected 0 0", bus.mayor, bus.paridad);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, rl;
    do_op(2'b00, 16'hFFFF, 16'h0001, lat, rl);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
    checks++; if (bus.q !== 16'h0000) begin errors++; $display("FAIL add_carry_q: got %h expected 0000", bus.q); end
    checks++; if (bus.mayor !== 1'b1 || bus.cero !== 1'b1 || bus.paridad !== 1'b0) begin
      errors++; $display("FAIL add_carry_flags: mayor=%b cero=%b paridad=%b expected 1 1 0", bus.mayor, bus.cero, bus.paridad);
    end
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL add_after: ready=%b valid=%b expected 1 0", bus.ready, bus.valid);
    end
    do_op(2'b00, 16'h1234, 16'h4321, lat, rl);
    checks++; if (bus.q !== 16'h5555 || bus.mayor !== 1'b0 || bus.paridad !== 1'b1 || bus.cero !== 1'b0) begin
      errors++; $display("FAIL add_plain: q=%h mayor=%b paridad=%b cero=%b expected 5555 0 1 0", bus.q, bus.mayor, bus.paridad, bus.cero);
    end
  endtask

  task automatic test_sub();
    int lat, rl;
    do_op(2'b10, 16'h0003, 16'h0005, lat, rl);
    checks++; if (bus.q !== 16'hFFFE || bus.mayor !== 1'b1 || lat !== 1) begin
      errors++; $display("FAIL sub_borrow: q=%h mayor=%b lat=%0d expected fffe 1 1", bus.q, bus.mayor, lat);
    end
    do_op(2'b10, 16'h0005, 16'h0003, lat, rl);
    checks++; if (bus.q !== 16'h0002 || bus.mayor !== 1'b0 || bus.paridad !== 1'b0) begin
      errors++; $display("FAIL sub_plain: q=%h mayor=%b paridad=%b expected 0002 0 0", bus.q, bus.mayor, bus.paridad);
    end
    do_op(2'b10, 16'h0007, 16'h0007, lat, rl);
    checks++; if (bus.q !== 16'h0000 || bus.mayor !== 1'b0 || bus.cero !== 1'b1) begin
      errors++; $display("FAIL sub_equal: q=%h mayor=%b cero=%b expected 0000 0 1", bus.q, bus.mayor, bus.cero);
    end
  endtask

  task automatic test_shr();
    int lat, rl;
    do_op(2'b01, 16'h800F, 16'hFFF4, lat, rl);
    checks++; if (lat !== 4 || rl !== 4) begin
      errors++; $display("FAIL shr4_timing: lat=%0d ready_low=%0d expected 4 4", lat, rl);
    end
    checks++; if (bus.q !== 16'h0800 || bus.mayor !== 1'b1) begin
      errors++; $display("FAIL shr4_result: q=%h mayor=%b expected 0800 1", bus.q, bus.mayor);
    end
    checks++; if (bus.paridad !== 1'b0 || bus.cero !== 1'b0) begin
      errors++; $display("FAIL shr4_flags: paridad=%b cero=%b expected 0 0", bus.paridad, bus.cero);
    end
    do_op(2'b01, 16'h0003, 16'h0001, lat, rl);
    checks++; if (lat !== 1 || bus.q !== 16'h0001 || bus.mayor !== 1'b1) begin
      errors++; $display("FAIL shr1: lat=%0d q=%h mayor=%b expected 1 0001 1", lat, bus.q, bus.mayor);
    end
  endtask

  task automatic test_shl();
    int lat, rl;
    do_op(2'b11, 16'h0001, 16'hFFF0, lat, rl);
    checks++; if (lat !== 1 || bus.q !== 16'h0001 || bus.mayor !== 1'b0) begin
      errors++; $display("FAIL shl0: lat=%0d q=%h mayor=%b expected 1 0001 0", lat, bus.q, bus.mayor);
    end
    do_op(2'b11, 16'h0003, 16'hFFFF, lat, rl);
    checks++; if (lat !== 15 || rl !== 15) begin
      errors++; $display("FAIL shl15_timing: lat=%0d ready_low=%0d expected 15 15", lat, rl);
    end
    checks++; if (bus.q !== 16'h8000 || bus.mayor !== 1'b1) begin
      errors++; $display("FAIL shl15_result: q=%h mayor=%b expected 8000 1", bus.q, bus.mayor);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rl;
    do_op(2'b00, 16'h00FF, 16'h0001, lat, rl);
    checks++; if (bus.q !== 16'h0100) begin errors++; $display("FAIL b2b_first: got %h expected 0100", bus.q); end
    do_op(2'b00, 16'h8000, 16'h8000, lat, rl);
    checks++; if (lat !== 1 || bus.q !== 16'h0000 || bus.mayor !== 1'b1) begin
      errors++; $display("FAIL b2b_second: lat=%0d q=%h mayor=%b expected 1 0000 1", lat, bus.q, bus.mayor);
    end
  endtask

  task automatic test_busy_abort();
    int lat, extra;
    // Shift right by 8 with an add pulsed during the busy window.
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_control = 2'b01; bus.i_a = 16'hFF80; bus.i_b = 16'h0008;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus.i_valid = (n == 3);
      if (n == 3) begin bus.i_control = 2'b00; bus.i_a = 16'h0001; bus.i_b = 16'h0001; end
      if (bus.valid) begin lat = n; break; end
    end
    bus.i_valid = 1'b0;
    checks++; if (lat !== 8 || bus.q !== 16'h00FF || bus.mayor !== 1'b1) begin
      errors++; $display("FAIL busy_shift: lat=%0d q=%h mayor=%b expected 8 00ff 1", lat, bus.q, bus.mayor);
    end
    extra = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus.valid) extra++;
    end
    checks++; if (extra !== 0 || bus.q !== 16'h00FF) begin
      errors++; $display("FAIL busy_not_queued: extra_valid=%0d q=%h expected 0 00ff", extra, bus.q);
    end
    // Same kind of shift, aborted by reset at cycle 5.
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_control = 2'b11; bus.i_a = 16'h00FF; bus.i_b = 16'h0008;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    extra = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (bus.valid) extra++;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.q !== 16'h0000 || bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
      errors++; $display("FAIL abort_reset: q=%h ready=%b valid=%b expected 0000 1 0", bus.q, bus.ready, bus.valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", extra); end
    do_op(2'b00, 16'h0002, 16'h0003, lat, extra);
    checks++; if (lat !== 1 || bus.q !== 16'h0005) begin
      errors++; $display("FAIL abort_recover: lat=%0d q=%h expected 1 0005", lat, bus.q);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_control = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_shr();
    test_shl();
    test_back_to_back();
    test_busy_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, width-parametrised successor to the team's 16-bit combinational ALU. It registers operands on a valid/ready handshake and performs add and subtract in one cycle. Variable-amount logical shifts run iteratively, one bit per cycle. It adds a zero flag and borrow/shift-out semantics for `mayor`. It sits between the register-file read ports and the C-bus write-back, and the controller sequences operations on `valid`.

## Interface
Parameters:
- `N`, 16, datapath width; power of two, ≥ 4.
- `SHW`, $clog2(N), shift-amount width; derived, not overridden.

Ports:
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_valid`  in  1  operation request.
- `ready`  out  1  block can accept; accept = `i_valid && ready` at a rising edge.
- `i_a`  in  N  operand A; shift source.
- `i_b`  in  N  operand B; for shifts only `i_b[SHW-1:0]` is used, as the amount k.
- `i_control`  in  2  opcode: 00 add, 10 sub, 01 shift right logical, 11 shift left logical.
- `q`  out  N  result; held until the next result.
- `mayor`  out  1  add: carry out; sub: borrow (`i_a < i_b` unsigned); shifts: last bit shifted out, 0 when k = 0.
- `paridad`  out  1  `q[0]`.
- `cero`  out  1  `q == 0`.
- `valid`  out  1  one-cycle pulse; `q` and the flags are new this cycle.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: `ready = 1`. On accept, `i_a`, `i_b[SHW-1:0]` and `i_control` are captured; later input changes are ignored.
  - add/sub: compute into an (N+1)-bit result; `q` = low N bits; `mayor` = bit N (add) or borrow (sub). Go to DONE.
  - shift, k = 0: `q = i_a`, `mayor = 0`. Go to DONE.
  - shift, k ≥ 1: load the working register with `i_a`, load the count with k. Go to SHIFT.
- SHIFT: `ready = 0`. Each edge shifts 1 bit, zero-filled. The bit leaving the register goes to `mayor` (LSB for right, MSB for left). The count decrements. When the count is 1 on that edge, go to DONE.
- DONE: `valid = 1` and `ready = 0` for exactly one cycle, then IDLE.
- `i_valid` while `ready = 0` is ignored; the request is not queued.
- `paridad` and `cero` derive combinationally from the registered `q`. They update only when a result is produced.
- Arithmetic wraps modulo 2^N. There is no signed overflow flag.

## Timing
- Reset (async assert, sync release is the system's job) gives:
  - `q = 0`, `mayor = 0`, `valid = 0`, `ready = 1`.
  - `cero = 1`, `paridad = 0`.
  - State IDLE, count 0.
- Latency L, measured from the accept edge to the `valid` cycle:
  - add/sub: L = 1.
  - shift: L = max(k, 1).
- `ready` is low for L cycles after the accept edge. It is high again in the cycle after `valid`. Back-to-back add throughput is 1 op per 2 cycles.
- Reset mid-SHIFT or during DONE: the operation is aborted, no `valid` is issued, and the outputs take their reset values.
- Max shift is k = N−1, giving L = N−1.

## Structure
- Package `alu_pkg`:
  - Opcode constants OP_ADD = 2'b00, OP_SUB = 2'b10, OP_SHR = 2'b01, OP_SHL = 2'b11.
  - FSM state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module `alu_shift_step`:
  - Purely combinational 1-bit shift of N bits.
  - Inputs: data and direction. Outputs: shifted data and out-bit.
  - Instantiated once in the SHIFT datapath.
- Top holds the FSM, operand/count registers, add/sub logic and flag logic.

## Test plan
1. Reset: assert `i_rst` asynchronously mid-cycle → immediately `q = 0`, `ready = 1`, `valid = 0`, `cero = 1`, `mayor = 0`.
2. Add with carry: 0xFFFF + 0x0001 (N = 16) → one cycle after accept, `valid = 1`, `q = 0x0000`, `mayor = 1`, `cero = 1`, `paridad = 0`.
3. Subtract: 0x0003 − 0x0005 → `q = 0xFFFE`, `mayor = 1`. Then 0x0005 − 0x0003 → `q = 0x0002`, `mayor = 0`, `paridad = 0`.
4. Shift right 0x800F by k = 4 → `ready` low 4 cycles; `valid` at cycle 4 after accept; `q = 0x0800`, `mayor = 1`, `paridad = 0`, `cero = 0`.
5. Shift left 0x0001 by k = 0 → L = 1, `q = 0x0001`, `mayor = 0`. Shift left 0x0003 by k = 15 → L = 15, `q = 0x8000`, `mayor = 1`.
6. Busy/abort:
   - Start shift k = 8. Pulse `i_valid` with add at cycle 3 → ignored; result is the shift's.
   - Repeat and assert `i_rst` at cycle 5 → no `valid` pulse, `q = 0`, `ready = 1`.
